// File: rtl/traffic_pkg.sv
// Shared lamp encodings, phase enum and lane indices for the junction scheduler.
package traffic_pkg;

  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  localparam logic [2:0] LAMP_ORANGE = 3'b010;
  localparam logic [2:0] LAMP_RED    = 3'b100;

  typedef enum logic [1:0] {
    PH_ALL_RED = 2'd0,
    PH_GREEN   = 2'd1,
    PH_ORANGE  = 2'd2
  } phase_t;

  localparam logic [1:0] LANE_A = 2'd0;
  localparam logic [1:0] LANE_B = 2'd1;
  localparam logic [1:0] LANE_C = 2'd2;
  localparam logic [1:0] LANE_D = 2'd3;

  function automatic logic [2:0] lamp_of(phase_t p, logic [1:0] act, logic [1:0] ln);
    logic [2:0] l;
    l = LAMP_RED;
    if (ln == act) begin
      if (p == PH_GREEN)  l = LAMP_GREEN;
      if (p == PH_ORANGE) l = LAMP_ORANGE;
    end
    return l;
  endfunction

endpackage

// File: rtl/lane_arbiter.sv
// Combinational next-lane selection: emergency (EMERGENCY_PREEMPT_EN), starvation,
// highest demand with round-robin ties, else re-grant of the active lane.
module lane_arbiter
  import traffic_pkg::*;
(
  input  logic [7:0] levels,
  input  logic [3:0] starved,
  input  logic [1:0] active_lane,
`ifdef EMERGENCY_PREEMPT_EN
  input  logic [3:0] emerg,
`endif
  output logic [1:0] granted
);

  logic       found;
  logic [1:0] idx;
  logic [1:0] cand;
  logic [1:0] best;
  logic [1:0] lvl;

  always_comb begin
    granted = active_lane;
    found   = 1'b0;
    idx     = active_lane;
    cand    = active_lane;
    best    = 2'd0;
    lvl     = 2'd0;
`ifdef EMERGENCY_PREEMPT_EN
    // Descending scan so the lowest-index emergency lane wins.
    for (int i = 3; i >= 0; i--) begin
      if (emerg[i]) begin
        granted = 2'(i);
        found   = 1'b1;
      end
    end
`endif
    // Search order starts after the active lane; k=4 wraps back to it last.
    for (int k = 1; k <= 4; k++) begin
      idx = active_lane + 2'(k);
      lvl = levels[{idx, 1'b0} +: 2];
      if (!found && starved[idx] && lvl != 2'd0) begin
        granted = idx;
        found   = 1'b1;
      end
    end
    for (int k = 1; k <= 4; k++) begin
      idx = active_lane + 2'(k);
      lvl = levels[{idx, 1'b0} +: 2];
      if (lvl > best) begin
        best = lvl;
        cand = idx;
      end
    end
    if (!found && best != 2'd0) granted = cand;
  end

endmodule

// File: rtl/junction_phase_scheduler.sv
// Four-approach junction sequencer: GREEN -> ORANGE -> ALL_RED with min/max green,
// demand arbitration and starvation counters. Optional EMERGENCY_PREEMPT_EN adds emerg[3:0].
module junction_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int GREEN_MIN    = 10,
  parameter int GREEN_MAX    = 30,
  parameter int ORANGE_T     = 3,
  parameter int ALLRED_T     = 1,
  parameter int STARVE_LIMIT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [1:0] Sa,
  input  logic [1:0] Sb,
  input  logic [1:0] Sc,
  input  logic [1:0] Sd,
`ifdef EMERGENCY_PREEMPT_EN
  input  logic [3:0] emerg,
`endif
  output logic [2:0] Ta,
  output logic [2:0] Tb,
  output logic [2:0] Tc,
  output logic [2:0] Td,
  output logic [1:0] active_lane,
  output logic [1:0] phase,
  output logic       grant_pulse
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  phase_t             ph;
  logic [4:0]         timer;
  logic [4:0]         timer_inc;
  logic [1:0]         lane;
  logic [3:0][SW-1:0] starve;
  logic [3:0]         starved;
  logic [1:0]         granted;
  logic [7:0]         levels;
  logic [1:0]         own;
  logic               other_dem;
  logic               other_hi;
  logic               end_ok;
  logic               green_end;

  assign levels    = {Sd, Sc, Sb, Sa};
  assign timer_inc = (timer == 5'd31) ? timer : timer + 5'd1;

  always_comb begin
    for (int i = 0; i < 4; i++) starved[i] = (starve[i] == SW'(STARVE_LIMIT));
  end

  lane_arbiter u_arb (
    .levels      (levels),
    .starved     (starved),
    .active_lane (lane),
`ifdef EMERGENCY_PREEMPT_EN
    .emerg       (emerg),
`endif
    .granted     (granted)
  );

  always_comb begin
    own       = levels[{lane, 1'b0} +: 2];
    other_dem = 1'b0;
    other_hi  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (2'(i) != lane) begin
        if (levels[i*2 +: 2] != 2'd0) other_dem = 1'b1;
        if (levels[i*2 +: 2] > own)   other_hi  = 1'b1;
      end
    end
    end_ok = (timer == 5'(GREEN_MAX - 1)) ||
             (timer >= 5'(GREEN_MIN - 1) && other_dem && (own == 2'd0 || other_hi));
`ifdef EMERGENCY_PREEMPT_EN
    // A foreign emergency preempts at once; an own emergency overrides every limit.
    green_end = (|(emerg & ~(4'b0001 << lane))) || (!emerg[lane] && end_ok);
`else
    green_end = end_ok;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ph          <= PH_ALL_RED;
      timer       <= 5'd0;
      lane        <= LANE_A;
      starve      <= '0;
      grant_pulse <= 1'b0;
    end else begin
      grant_pulse <= 1'b0;
      if (tick) begin
        case (ph)
          PH_ALL_RED: begin
            if (timer == 5'(ALLRED_T - 1)) begin
              ph          <= PH_GREEN;
              timer       <= 5'd0;
              lane        <= granted;
              grant_pulse <= 1'b1;
              for (int i = 0; i < 4; i++) begin
                if (2'(i) == granted || levels[i*2 +: 2] == 2'd0)
                  starve[i] <= '0;
                else if (!starved[i])
                  starve[i] <= starve[i] + 1'b1;
              end
            end else begin
              timer <= timer_inc;
            end
          end
          PH_GREEN: begin
            if (green_end) begin
              ph    <= PH_ORANGE;
              timer <= 5'd0;
            end else begin
              timer <= timer_inc;
            end
          end
          PH_ORANGE: begin
            if (timer == 5'(ORANGE_T - 1)) begin
              ph    <= PH_ALL_RED;
              timer <= 5'd0;
            end else begin
              timer <= timer_inc;
            end
          end
          default: begin
            ph    <= PH_ALL_RED;
            timer <= 5'd0;
          end
        endcase
      end
    end
  end

  assign Ta          = lamp_of(ph, lane, LANE_A);
  assign Tb          = lamp_of(ph, lane, LANE_B);
  assign Tc          = lamp_of(ph, lane, LANE_C);
  assign Td          = lamp_of(ph, lane, LANE_D);
  assign active_lane = lane;
  assign phase       = ph;

endmodule

// File: tb/tb_junction_phase_scheduler.sv
// Bench: cycle model predicts phase/lane/lamps; predicted grants go through a scoreboard queue.
module tb_junction_phase_scheduler;

  localparam int GMIN = 10, GMAX = 30, OT = 3, AT = 1, SL = 3;

  logic       clk = 1'b0;
  logic       rst, tick;
  logic [1:0] s [4];
  logic [2:0] Ta, Tb, Tc, Td;
  logic [1:0] active_lane, phase;
  logic       grant_pulse;
`ifdef EMERGENCY_PREEMPT_EN
  logic [3:0] emerg;
`endif

  junction_phase_scheduler dut (
    .clk(clk), .rst(rst), .tick(tick),
    .Sa(s[0]), .Sb(s[1]), .Sc(s[2]), .Sd(s[3]),
`ifdef EMERGENCY_PREEMPT_EN
    .emerg(emerg),
`endif
    .Ta(Ta), .Tb(Tb), .Tc(Tc), .Td(Td),
    .active_lane(active_lane), .phase(phase), .grant_pulse(grant_pulse)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int exp_q[$];
  int m_ph, m_tm, m_ln;
  int m_st [4];
  bit m_gp;
  int tick_div = 1;
  int cyc_n = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  function automatic int m_arb();
    int idx, best, cand;
`ifdef EMERGENCY_PREEMPT_EN
    for (int i = 0; i < 4; i++) if (emerg[i]) return i;
`endif
    for (int k = 1; k <= 4; k++) begin
      idx = (m_ln + k) % 4;
      if (m_st[idx] == SL && s[idx] != 0) return idx;
    end
    best = 0; cand = m_ln;
    for (int k = 1; k <= 4; k++) begin
      idx = (m_ln + k) % 4;
      if (int'(s[idx]) > best) begin best = int'(s[idx]); cand = idx; end
    end
    return cand;
  endfunction

  task automatic m_step();
    int g, own;
    bit od, oh, e;
    if (rst) begin
      m_ph = 0; m_tm = 0; m_ln = 0; m_gp = 0;
      for (int i = 0; i < 4; i++) m_st[i] = 0;
      return;
    end
    m_gp = 0;
    if (!tick) return;
    if (m_ph == 0) begin
      if (m_tm == AT - 1) begin
        g = m_arb();
        for (int i = 0; i < 4; i++)
          if (i == g || s[i] == 0) m_st[i] = 0;
          else if (m_st[i] < SL) m_st[i]++;
        m_ln = g; m_ph = 1; m_tm = 0; m_gp = 1;
        exp_q.push_back(g);
      end else m_tm++;
    end else if (m_ph == 1) begin
      own = int'(s[m_ln]); od = 0; oh = 0;
      for (int i = 0; i < 4; i++)
        if (i != m_ln) begin
          if (s[i] != 0) od = 1;
          if (int'(s[i]) > own) oh = 1;
        end
      e = (m_tm == GMAX - 1) || (m_tm >= GMIN - 1 && od && (own == 0 || oh));
`ifdef EMERGENCY_PREEMPT_EN
      e = ((emerg & ~(4'b0001 << m_ln)) != 0) || (!emerg[m_ln] && e);
`endif
      if (e) begin m_ph = 2; m_tm = 0; end
      else if (m_tm < 31) m_tm++;
    end else begin
      if (m_tm == OT - 1) begin m_ph = 0; m_tm = 0; end
      else m_tm++;
    end
  endtask

  // One clock: model update at the edge, compare 1 time unit later, then set next tick.
  task automatic cyc();
    logic [2:0] lamps [4];
    int want;
    @(posedge clk);
    m_step();
    #1;
    lamps[0] = Ta; lamps[1] = Tb; lamps[2] = Tc; lamps[3] = Td;
    chk("phase", phase, m_ph);
    chk("lane", active_lane, m_ln);
    chk("pulse", grant_pulse, m_gp);
    for (int i = 0; i < 4; i++) begin
      want = (i == m_ln && m_ph == 1) ? 1 : (i == m_ln && m_ph == 2) ? 2 : 4;
      chk($sformatf("lamp%0d", i), lamps[i], want);
    end
    if (grant_pulse === 1'b1) begin
      if (exp_q.size() == 0) chk("sb_empty", 1, 0);
      else chk("sb_lane", active_lane, exp_q.pop_front());
    end
    cyc_n++;
    tick = ((cyc_n % tick_div) == 0);
  endtask

  task automatic next_grant(output int ln);
    ln = -1;
    for (int n = 0; n < 300; n++) begin
      cyc();
      if (grant_pulse === 1'b1) begin ln = int'(active_lane); return; end
    end
    chk("grant_timeout", 0, 1);
  endtask

  task automatic count_phase(input int p, output int n);
    n = 0;
    while (phase === 2'(p) && n < 300) begin n++; cyc(); end
  endtask

  int l, g, o, a, d;
  int seq [5] = '{2, 3, 0, 1, 2};

  initial begin
    rst = 1'b1; tick = 1'b1;
    for (int i = 0; i < 4; i++) s[i] = 2'd0;
`ifdef EMERGENCY_PREEMPT_EN
    emerg = 4'b0;
`endif
    cyc(); cyc();
    chk("rst_phase", phase, 0);
    chk("rst_lane", active_lane, 0);
    chk("rst_pulse", grant_pulse, 0);
    chk("rst_lamps", {Ta, Tb, Tc, Td}, 12'b100_100_100_100);
    rst = 1'b0;

    // Lone demand on A: full max green, then re-grant of A.
    s[0] = 2'd3;
    next_grant(l);            chk("t1_lane", l, 0);
    count_phase(1, g);        chk("t1_green", g, GMAX);
    count_phase(2, o);        chk("t1_orange", o, OT);
    count_phase(0, a);        chk("t1_allred", a, AT);
    chk("t1_regrant_pulse", grant_pulse, 1);
    chk("t1_regrant_lane", active_lane, 0);

    // Higher demand on B ends A's green at GREEN_MIN.
    s[0] = 2'd1; s[1] = 2'd2;
    count_phase(1, g);        chk("t2_green", g, GMIN);
    count_phase(2, o);        chk("t2_orange", o, OT);
    count_phase(0, a);        chk("t2_allred", a, AT);
    chk("t2_lane", active_lane, 1);

    // Equal demand everywhere: rotation, with sparse ticks.
    for (int i = 0; i < 4; i++) s[i] = 2'd2;
    tick_div = 2;
    for (int k = 0; k < 5; k++) begin
      next_grant(l);
      chk($sformatf("t3_rot%0d", k), l, seq[k]);
    end

    // Heavy A, light C: C forced in on its 4th decision.
    tick_div = 1;
    s[0] = 2'd3; s[1] = 2'd0; s[2] = 2'd0; s[3] = 2'd0;
    next_grant(l);            chk("t4_first", l, 0);
    s[2] = 2'd1;
    d = 0;
    for (int k = 1; k <= 6; k++) begin
      next_grant(l);
      d = k;
      if (l == 2) break;
    end
    chk("t4_decisions", d, 4);

    // Reset pulse in the middle of orange.
    for (int n = 0; n < 300 && phase !== 2'd2; n++) cyc();
    chk("t5_in_orange", phase, 2);
    rst = 1'b1;
    cyc();
    chk("t5_phase", phase, 0);
    chk("t5_lane", active_lane, 0);
    chk("t5_lamps", {Ta, Tb, Tc, Td}, 12'b100_100_100_100);
    rst = 1'b0;
    next_grant(l);            chk("t5_after", l, 0);

`ifdef EMERGENCY_PREEMPT_EN
    // Emergency on C preempts A's green at timer 2.
    cyc(); cyc();
    emerg = 4'b0100;
    cyc();
    chk("t6_orange", phase, 2);
    next_grant(l);            chk("t6_lane", l, 2);
    emerg = 4'b0000;
`endif

    cyc();
    chk("sb_left", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
